monolith_concrete_seq: RTL and testbench



---
 rtl/monolith_pkg.sv | 42 ++++
 rtl/monolith_concrete_row.sv | 40 ++++
 rtl/monolith_concrete_seq.sv | 99 +++++++++
 tb/tb_monolith_concrete_seq.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/monolith_pkg.sv
// monolith_pkg
//   Shared definitions for the Monolith-31 Concrete (MDS) layer:
//   field modulus, circulant first row, state type, FSM encoding and the
//   Mersenne-prime reduction helper.
package monolith_pkg;

    localparam int unsigned WORD_W  = 31;
    localparam int unsigned STATE_N = 16;
    localparam int unsigned COEF_W  = 8;
    // 16 terms of (31-bit * 8-bit) products fit in 43 bits; 44 leaves headroom.
    localparam int unsigned ACC_W   = 44;

    localparam logic [WORD_W-1:0] P = 31'h7FFFFFFF;

    // First row of the circulant Concrete matrix: M[i][j] = MDS_ROW[(j-i) mod 16].
    localparam logic [COEF_W-1:0] MDS_ROW [0:STATE_N-1] = '{
        8'd1,   8'd1,  8'd51, 8'd1,  8'd11, 8'd17, 8'd2,  8'd1,
        8'd101, 8'd63, 8'd15, 8'd2,  8'd67, 8'd22, 8'd13, 8'd3
    };

    typedef logic [WORD_W-1:0] state_t [0:STATE_N-1];

    typedef enum logic [1:0] {
        S_IDLE,
        S_COMPUTE,
        S_DONE
    } conc_state_e;

    // Two folds bring a 44-bit value to at most P+1; one conditional subtract
    // makes it canonical.
    function automatic logic [WORD_W-1:0] mersenne_reduce(input logic [ACC_W-1:0] x);
        logic [WORD_W:0] f1;
        logic [WORD_W:0] f2;
        f1 = {1'b0, x[WORD_W-1:0]} + (WORD_W+1)'(x[ACC_W-1:WORD_W]);
        f2 = {1'b0, f1[WORD_W-1:0]} + (WORD_W+1)'(f1[WORD_W]);
        if (f2 >= {1'b0, P}) begin
            f2 = f2 - {1'b0, P};
        end
        return f2[WORD_W-1:0];
    endfunction

endpackage

// File: rtl/monolith_concrete_row.sv
// monolith_concrete_row
//   Combinational computation of one output row of the Concrete layer:
//   y = sum_j MDS_ROW[(j-row) mod N] * x[j]  mod p.
// Ports:
//   x_i   latched input state (STATE_SIZE words)
//   row_i row index to compute
//   y_o   reduced, canonical row value
module monolith_concrete_row
    import monolith_pkg::*;
#(
    parameter int unsigned WORD_WIDTH = 31,
    parameter int unsigned STATE_SIZE = 16,
    parameter int unsigned COEF_WIDTH = 8
) (
    input  logic [WORD_WIDTH-1:0]         x_i [0:STATE_SIZE-1],
    input  logic [$clog2(STATE_SIZE)-1:0] row_i,
    output logic [WORD_WIDTH-1:0]         y_o
);

    localparam int unsigned IDX_W = $clog2(STATE_SIZE);

    logic [ACC_W-1:0]      acc;
    logic [IDX_W-1:0]      idx;
    logic [COEF_WIDTH-1:0] coef;

    always_comb begin
        acc  = '0;
        idx  = '0;
        coef = '0;
        for (int unsigned j = 0; j < STATE_SIZE; j++) begin
            // IDX_W-bit subtraction wraps, giving (j - row) mod STATE_SIZE.
            idx  = IDX_W'(j) - row_i;
            coef = MDS_ROW[idx];
            acc  = acc + ACC_W'(coef) * ACC_W'(x_i[j]);
        end
    end

    assign y_o = mersenne_reduce(acc);

endmodule

// File: rtl/monolith_concrete_seq.sv
// monolith_concrete_seq
//   Iterative Concrete (MDS) layer of Monolith-31. Latches a state on the
//   input handshake, computes ROWS_PER_CYCLE rows per cycle, then holds the
//   result until the consumer takes it.
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   in_valid / in_ready  input handshake (in_ready high only in IDLE)
//   state_in             input state, sampled on acceptance only
//   out_valid / out_ready output handshake
//   state_out            result, meaningful while out_valid is high
module monolith_concrete_seq
    import monolith_pkg::*;
#(
    parameter int unsigned WORD_WIDTH     = 31,
    parameter int unsigned STATE_SIZE     = 16,
    parameter int unsigned ROWS_PER_CYCLE = 1,
    parameter int unsigned COEF_WIDTH     = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WORD_WIDTH-1:0] state_in  [0:STATE_SIZE-1],
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [WORD_WIDTH-1:0] state_out [0:STATE_SIZE-1]
);

    localparam int unsigned N     = STATE_SIZE / ROWS_PER_CYCLE;
    localparam int unsigned CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam int unsigned ROW_W = $clog2(STATE_SIZE);

    conc_state_e           state_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  out_valid_q;
    logic [WORD_WIDTH-1:0] x_q   [0:STATE_SIZE-1];
    logic [WORD_WIDTH-1:0] out_q [0:STATE_SIZE-1];

    logic [ROW_W-1:0]      row_idx [0:ROWS_PER_CYCLE-1];
    logic [WORD_WIDTH-1:0] row_val [0:ROWS_PER_CYCLE-1];

    for (genvar g = 0; g < ROWS_PER_CYCLE; g++) begin : g_row
        assign row_idx[g] = ROW_W'(32'(cnt_q) * ROWS_PER_CYCLE + g);

        monolith_concrete_row #(
            .WORD_WIDTH (WORD_WIDTH),
            .STATE_SIZE (STATE_SIZE),
            .COEF_WIDTH (COEF_WIDTH)
        ) u_row (
            .x_i   (x_q),
            .row_i (row_idx[g]),
            .y_o   (row_val[g])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            out_valid_q <= 1'b0;
            x_q         <= '{default: '0};
            out_q       <= '{default: '0};
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
                        x_q     <= state_in;
                        cnt_q   <= '0;
                        state_q <= S_COMPUTE;
                    end
                end
                S_COMPUTE: begin
                    for (int unsigned g = 0; g < ROWS_PER_CYCLE; g++) begin
                        out_q[row_idx[g]] <= row_val[g];
                    end
                    if (cnt_q == CNT_W'(N - 1)) begin
                        cnt_q       <= '0;
                        out_valid_q <= 1'b1;
                        state_q     <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CNT_W'(1);
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        out_valid_q <= 1'b0;
                        state_q     <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (state_q == S_IDLE);
    assign out_valid = out_valid_q;
    assign state_out = out_q;

endmodule

// File: tb/tb_monolith_concrete_seq.sv
module tb_monolith_concrete_seq;

    typedef logic [30:0] vec_t [0:15];

    localparam longint unsigned PM = 64'd2147483647;
    localparam int unsigned COEF [0:15] = '{1, 1, 51, 1, 11, 17, 2, 1, 101, 63, 15, 2, 67, 22, 13, 3};
    localparam int LAT [0:1] = '{16, 4};

    logic clk = 1'b0;
    logic reset = 1'b1;

    logic a_in_valid = 1'b0, a_in_ready, a_out_valid, a_out_ready = 1'b0;
    logic b_in_valid = 1'b0, b_in_ready, b_out_valid, b_out_ready = 1'b0;
    vec_t a_sin, a_sout, b_sin, b_sout;

    int tests = 0;
    int fails = 0;
    int cyc = 0;

    monolith_concrete_seq #(.ROWS_PER_CYCLE(1)) u_dut1 (
        .clk(clk), .reset(reset),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .state_in(a_sin),
        .out_valid(a_out_valid), .out_ready(a_out_ready), .state_out(a_sout)
    );

    monolith_concrete_seq #(.ROWS_PER_CYCLE(4)) u_dut4 (
        .clk(clk), .reset(reset),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .state_in(b_sin),
        .out_valid(b_out_valid), .out_ready(b_out_ready), .state_out(b_sout)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic void chk(input string nm, input bit ok, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (!ok) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Golden model: plain matrix-vector product modulo p.
    function automatic vec_t model(input vec_t x);
        vec_t r;
        longint unsigned acc;
        for (int i = 0; i < 16; i++) begin
            acc = 0;
            for (int j = 0; j < 16; j++)
                acc += longint'(COEF[(j - i + 16) % 16]) * longint'(x[j]);
            r[i] = 31'(acc % PM);
        end
        return r;
    endfunction

    function automatic bit get_in_ready(input int d);
        return (d == 0) ? a_in_ready : b_in_ready;
    endfunction

    function automatic bit get_out_valid(input int d);
        return (d == 0) ? a_out_valid : b_out_valid;
    endfunction

    function automatic vec_t get_out(input int d);
        return (d == 0) ? a_sout : b_sout;
    endfunction

    task automatic drive(input int d, input bit v, input vec_t x);
        if (d == 0) begin a_in_valid = v; a_sin = x; end
        else        begin b_in_valid = v; b_sin = x; end
    endtask

    task automatic set_ready(input int d, input bit r);
        if (d == 0) a_out_ready = r; else b_out_ready = r;
    endtask

    task automatic send(input int d, input vec_t x);
        int n;
        n = 0;
        drive(d, 1'b1, x);
        forever begin
            @(negedge clk);
            if (get_in_ready(d)) break;
            n++;
            if (n > 100) begin
                chk("send_timeout", 1'b0, 0, 1);
                break;
            end
        end
        @(posedge clk); #1;
        drive(d, 1'b0, x);
    endtask

    task automatic wait_valid(input int d);
        int n;
        n = 0;
        forever begin
            @(negedge clk);
            if (get_out_valid(d)) break;
            n++;
            if (n > 100) begin
                chk("out_valid_timeout", 1'b0, 0, 1);
                break;
            end
        end
    endtask

    task automatic run_vec(input int d, input vec_t x);
        send(d, x);
        wait_valid(d);
        @(posedge clk); #1;
    endtask

    task automatic chk_const(input int d, input string nm, input logic [30:0] v);
        vec_t o;
        int bad;
        o = get_out(d);
        bad = -1;
        for (int i = 0; i < 16; i++)
            if (bad < 0 && o[i] !== v) bad = i;
        chk(nm, bad < 0, o[(bad < 0) ? 0 : bad], v);
    endtask

    // Cycle-by-cycle compare against the model.
    vec_t expv [0:1];
    bit   busy [0:1] = '{0, 0};
    bit   seen [0:1] = '{0, 0};
    int   acc_edge [0:1] = '{0, 0};

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            vec_t so, si;
            bit ov, ir, iv, orr;
            int bad;
            if (d == 0) begin ov = a_out_valid; ir = a_in_ready; iv = a_in_valid; orr = a_out_ready; so = a_sout; si = a_sin; end
            else        begin ov = b_out_valid; ir = b_in_ready; iv = b_in_valid; orr = b_out_ready; so = b_sout; si = b_sin; end
            if (reset) begin
                busy[d] = 1'b0;
                seen[d] = 1'b0;
            end else begin
                if (busy[d]) begin
                    chk("in_ready_low_while_busy", !ir, ir, 0);
                end else begin
                    chk("in_ready_high_idle", ir, ir, 1);
                    chk("out_valid_low_idle", !ov, ov, 0);
                end
                if (busy[d] && ov) begin
                    if (!seen[d]) begin
                        chk("latency", (cyc - acc_edge[d]) == LAT[d], cyc - acc_edge[d], LAT[d]);
                        seen[d] = 1'b1;
                    end
                    bad = -1;
                    for (int i = 0; i < 16; i++)
                        if (bad < 0 && so[i] !== expv[d][i]) bad = i;
                    chk($sformatf("state_out[%0d] dut%0d", (bad < 0) ? 0 : bad, d), bad < 0,
                        so[(bad < 0) ? 0 : bad], expv[d][(bad < 0) ? 0 : bad]);
                    if (orr) busy[d] = 1'b0;
                end
                if (iv && ir) begin
                    expv[d]     = model(si);
                    busy[d]     = 1'b1;
                    seen[d]     = 1'b0;
                    acc_edge[d] = cyc + 1;
                end
            end
        end
    end

    initial begin
        vec_t z, x, x2;
        for (int i = 0; i < 16; i++) z[i] = '0;
        a_sin = z;
        b_sin = z;

        // Reset
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            chk("reset_out_valid", get_out_valid(d) == 1'b0, get_out_valid(d), 0);
            chk("reset_in_ready", get_in_ready(d) == 1'b1, get_in_ready(d), 1);
            chk_const(d, "reset_state_out", 31'd0);
        end
        @(posedge clk); #1;

        // Unit vector e0: out[i] = MDS_ROW[(16-i) mod 16]
        set_ready(0, 1'b1);
        x = z; x[0] = 31'd1;
        send(0, x);
        wait_valid(0);
        chk("e0_out0", a_sout[0] == 31'd1, a_sout[0], 1);
        chk("e0_out1", a_sout[1] == 31'd3, a_sout[1], 3);
        chk("e0_out2", a_sout[2] == 31'd13, a_sout[2], 13);
        chk("e0_out8", a_sout[8] == 31'd101, a_sout[8], 101);
        chk("e0_out15", a_sout[15] == 31'd1, a_sout[15], 1);
        @(posedge clk); #1;

        // All p-1: every row = -371 mod p
        for (int i = 0; i < 16; i++) x[i] = 31'h7FFFFFFE;
        send(0, x);
        wait_valid(0);
        chk_const(0, "all_pm1", 31'h7FFFFE8C);
        @(posedge clk); #1;

        // All 0x7FFFFFFF (== 0 mod p)
        for (int i = 0; i < 16; i++) x[i] = 31'h7FFFFFFF;
        send(0, x);
        wait_valid(0);
        chk_const(0, "all_p", 31'd0);
        @(posedge clk); #1;

        // Backpressure with a second state waiting
        set_ready(0, 1'b0);
        for (int i = 0; i < 16; i++) begin
            x[i]  = 31'(32'h1234567 * (i + 1));
            x2[i] = 31'h7FFFFFFE - 31'(i * 1000003);
        end
        send(0, x);
        wait_valid(0);
        for (int k = 0; k < 5; k++) begin
            @(posedge clk); #1;
            drive(0, 1'b1, x2);
            @(negedge clk);
            chk("bp_in_ready", a_in_ready == 1'b0, a_in_ready, 0);
            chk("bp_out_valid", a_out_valid == 1'b1, a_out_valid, 1);
        end
        @(posedge clk); #1 set_ready(0, 1'b1);
        @(posedge clk); #1 set_ready(0, 1'b0);
        @(negedge clk);
        chk("bp_idle_after_hs", a_in_ready == 1'b1 && a_out_valid == 1'b0, {a_in_ready, a_out_valid}, 2'b10);
        @(posedge clk); #1 drive(0, 1'b0, x2);
        set_ready(0, 1'b1);
        wait_valid(0);
        @(posedge clk); #1;

        // Reset on the 7th COMPUTE edge
        x = z; x[0] = 31'd1;
        send(0, x);
        repeat (6) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk); #1 reset = 1'b0;
        @(negedge clk);
        chk("rst_mid_out_valid", a_out_valid == 1'b0, a_out_valid, 0);
        chk("rst_mid_in_ready", a_in_ready == 1'b1, a_in_ready, 1);
        chk_const(0, "rst_mid_state_out", 31'd0);
        @(posedge clk); #1;
        send(0, x);
        wait_valid(0);
        chk("rst_e0_out0", a_sout[0] == 31'd1, a_sout[0], 1);
        chk("rst_e0_out1", a_sout[1] == 31'd3, a_sout[1], 3);
        @(posedge clk); #1;

        // Random vectors on both configurations
        set_ready(1, 1'b1);
        for (int d = 0; d < 2; d++) begin
            for (int n = 0; n < 1000; n++) begin
                for (int i = 0; i < 16; i++) x[i] = 31'($urandom_range(32'h7FFFFFFE, 0));
                run_vec(d, x);
            end
        end

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
